// File: rtl/uip_freq_meter.sv
// uip_freq_meter: counts rising edges of an asynchronous oscillator input
// over a programmable gate window of clk cycles. The result is latched and
// read back one byte at a time.
// Optional build macro UIP_FREQ_CONT_EN: while start is held high, the meter
// re-arms straight after each window. done then pulses for one cycle per
// completed window.
module uip_freq_meter #(
   parameter int CNT_W       = 24,
   parameter int GATE_W      = 16,
   parameter int GATE_CYCLES = 10000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sig_in,
   input  logic       start,
   input  logic [1:0] byte_sel,
   output logic [7:0] data_out,
   output logic       busy,
   output logic       done,
   output logic       ovf
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_COUNT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   // Saturating increment: the edge count sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic             inc);
      if (inc && (v != CNT_MAX)) begin
         sat_inc = v + CNT_ONE;
      end else begin
         sat_inc = v;
      end
   endfunction

   state_t              state_r;
   state_t              state_s;
   logic                sync1_r;
   logic                sync2_r;
   logic                prev_r;
   logic                rise_s;
   logic [GATE_W-1:0]   gate_cnt_r;
   logic [CNT_W-1:0]    edge_cnt_r;
   logic                ovf_flag_r;
   logic                edge_full_s;
   logic                gate_end_s;
   logic [CNT_W-1:0]    result_r;
   logic                ovf_r;
   logic                busy_r;
   logic                done_r;
   logic [31:0]         res_ext_s;
   logic [7:0]          data_s;

   // Two-flop synchronizer for the asynchronous input, plus a delayed copy for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         prev_r  <= 1'b0;
      end else begin
         sync1_r <= sig_in;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
      end
   end

   // Rising-edge pulse, saturation detect and last-gate-cycle detect.
   always_comb begin
      rise_s      = sync2_r & ~prev_r;
      edge_full_s = (edge_cnt_r == CNT_MAX);
      gate_end_s  = (state_r == ST_COUNT) && (gate_cnt_r == GATE_LAST);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic; start is only looked at in IDLE and DONE (and at gate end when continuous).
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = ST_ARM;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ARM: begin
            state_s = ST_COUNT;
         end
         ST_COUNT: begin
            if (gate_end_s) begin
`ifdef UIP_FREQ_CONT_EN
               if (start) begin
                  state_s = ST_ARM;
               end else begin
                  state_s = ST_DONE;
               end
`else
               state_s = ST_DONE;
`endif
            end else begin
               state_s = ST_COUNT;
            end
         end
         ST_DONE: begin
            if (start) begin
               state_s = ST_ARM;
            end else begin
               state_s = ST_DONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Gate and edge counters: cleared in ARM, advanced only during COUNT.
   always_ff @(posedge clk) begin
      if (rst) begin
         gate_cnt_r <= {GATE_W{1'b0}};
         edge_cnt_r <= {CNT_W{1'b0}};
         ovf_flag_r <= 1'b0;
      end else begin
         case (state_r)
            ST_ARM: begin
               gate_cnt_r <= {GATE_W{1'b0}};
               edge_cnt_r <= {CNT_W{1'b0}};
               ovf_flag_r <= 1'b0;
            end
            ST_COUNT: begin
               gate_cnt_r <= gate_cnt_r + GATE_ONE;
               edge_cnt_r <= sat_inc(edge_cnt_r, rise_s);
               ovf_flag_r <= ovf_flag_r | (rise_s & edge_full_s);
            end
            default: begin
               gate_cnt_r <= gate_cnt_r;
               edge_cnt_r <= edge_cnt_r;
               ovf_flag_r <= ovf_flag_r;
            end
         endcase
      end
   end

   // Result latch: captures the count including the last gate cycle's rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_r <= {CNT_W{1'b0}};
         ovf_r    <= 1'b0;
      end else if (gate_end_s) begin
         result_r <= sat_inc(edge_cnt_r, rise_s);
         ovf_r    <= ovf_flag_r | (rise_s & edge_full_s);
      end else begin
         result_r <= result_r;
         ovf_r    <= ovf_r;
      end
   end

   // Registered status flags, aligned with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (state_s == ST_ARM) || (state_s == ST_COUNT);
         done_r <= (state_s == ST_DONE) || gate_end_s;
      end
   end

   // Byte readout of the zero-extended result.
   always_comb begin
      res_ext_s              = 32'd0;
      res_ext_s[CNT_W-1:0]   = result_r;
      case (byte_sel)
         2'd0:    data_s = res_ext_s[7:0];
         2'd1:    data_s = res_ext_s[15:8];
         2'd2:    data_s = res_ext_s[23:16];
         2'd3:    data_s = res_ext_s[31:24];
         default: data_s = 8'd0;
      endcase
   end

   assign data_out = data_s;
   assign busy     = busy_r;
   assign done     = done_r;
   assign ovf      = ovf_r;

endmodule

// File: doc/uip_freq_meter.md
Name: uip_freq_meter

Overview:
- Digital frequency/edge-count front end for the analog IP tile. Sits directly downstream of the analog macro.
- An analog oscillator/comparator output is routed back through a dedicated input (`sig_in`). The block counts its rising edges over a programmable gate window of `clk` cycles.
- The result is latched and presented byte-wise on the dedicated outputs, so a tester can read oscillator frequency without external instruments.

Parameters:
- CNT_W, 24, edge-counter/result width in bits (4..32).
- GATE_W, 16, gate-counter width in bits.
- GATE_CYCLES, 10000, gate window length in `clk` cycles (1..2^GATE_W-1).

Ports:
- clk  input  1  system clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- sig_in  input  1  asynchronous square wave from the analog macro.
- start  input  1  level-sampled request to begin a measurement.
- byte_sel  input  2  selects result byte for data_out.
- data_out  output  8  selected result byte.
- busy  output  1  high while a measurement is in progress (ARM or COUNT).
- done  output  1  high while a valid result is held.
- ovf  output  1  edge count saturated during last measurement.

Behaviour:
- Reset: rst sampled on rising clk only.
  - State to IDLE; gate counter, edge counter, result, sync flops and prev flop all 0.
  - Outputs: data_out=0, busy=0, done=0, ovf=0.
  - Reset mid-measurement aborts with no result retained.
- Input conditioning: sig_in passes through 2-flop synchronizer s1->s2, then prev<=s2.
  - rise = s2 & ~prev.
  - sig_in rising edge to rise pulse: 3 clk edges worst case.
  - Glitches shorter than one clk period may be missed; this is accepted.
- FSM:
  - IDLE: busy=0, done=0. If start=1 go to ARM.
  - ARM (1 cycle): clear edge counter, ovf and gate counter; busy=1, done=0. Go to COUNT.
  - COUNT: busy=1. Exactly GATE_CYCLES cycles.
    - Each cycle, if rise=1: if edge counter is all-ones, hold it and set internal ovf flag; otherwise increment by 1.
    - Gate counter increments every cycle.
    - On the cycle the gate counter equals GATE_CYCLES-1: result <= edge counter plus that cycle's rise, with saturation applied; ovf output <= flag. Then go to DONE.
  - DONE: busy=0, done=1, result and ovf held. If start=1 go to ARM; done drops on the ARM cycle.
- start is ignored in ARM and COUNT; no queuing.
- Only rise pulses occurring in COUNT cycles are counted. ARM-cycle and DONE-cycle rises are discarded.
- Readout: data_out = result[8*byte_sel +: 8], combinational from the registered result.
  - Bits above CNT_W read 0.
  - byte_sel selecting a byte entirely above CNT_W returns 0x00.
  - data_out reflects the previous result until DONE is re-entered, including while busy.
- Width rule: the edge counter never wraps; saturation at 2^CNT_W-1 is mandatory.

Optional Feature:
- Macro: UIP_FREQ_CONT_EN.
- Defined: DONE with start=1 still goes to ARM. COUNT completion goes straight to ARM (not DONE) while start is held high.
  - result/ovf update at each gate end; done pulses high for exactly 1 cycle per completed window.
  - Dropping start lets the window in progress finish, then the FSM enters DONE and holds.
- Not defined: single-shot only, exactly as in Behaviour.

Test Plan:
- Periodic count: GATE_CYCLES=64, sig_in period 4 clk (2 high/2 low), start pulse 1 cycle. Expected: busy high 65 cycles (ARM+64); done=1; result=16; byte_sel=0 -> 0x10; byte_sel=1/2/3 -> 0x00; ovf=0.
- Saturation: CNT_W=4, GATE_CYCLES=64, sig_in period 2 clk (32 edges). Expected: result=0xF, data_out=0x0F, ovf=1. A rerun with sig_in held low gives result=0, ovf=0.
- Start ignored: assert start again 10 cycles into COUNT. Expected: no restart; done asserts exactly 64 cycles after ARM; one measurement only.
- Reset mid-count: rst=1 for 1 cycle at COUNT cycle 30. Expected: next cycle busy=0, done=0, data_out=0, ovf=0. A new start then yields the correct full-window count (16 for the period-4 stimulus).
- Boundary/wide value: CNT_W=24, GATE_CYCLES=1000, sig_in period 2 clk. Expected: result=500 = 0x0001F4; byte_sel 0/1/2 -> 0xF4/0x01/0x00. With sig_in held high throughout: result=0 (no rising edge).
- With UIP_FREQ_CONT_EN: hold start=1, GATE_CYCLES=64, period-4 input. Expected: done one-cycle pulses every 65 cycles; result=16 each window. Deassert start mid-window: that window completes, then done stays high.
